// File: rtl/sqrt_gen_pkg.sv
// Shared types and constants for the sequential restoring square-root unit.
// Holds the FSM encoding, the default radicand width and the counter sizing rule.
package sqrt_gen_pkg;

  localparam int SQRT_DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } sqrt_state_t;

  // The iteration counter must count down from RW-1; never narrower than one bit.
  function automatic int sqrt_cnt_width(input int rw);
    return (rw > 2) ? $clog2(rw) : 1;
  endfunction

endpackage

// File: rtl/sqrt_gen_step.sv
// One restoring square-root iteration: brings down two radicand bits and
// tries to subtract (root<<2)|1 from the widened partial remainder.
module sqrt_gen_step #(
  parameter int RW = 8
) (
  input  logic [RW-1:0] root_i,
  input  logic [RW+1:0] rem_i,
  input  logic [1:0]    bits_i,
  output logic [RW-1:0] root_o,
  output logic [RW+1:0] rem_o
);

  logic [RW+1:0] rem_sh;
  logic [RW+1:0] trial;
  logic          fits;

  // The remainder never exceeds 2*root, so the shifted value always fits RW+2 bits.
  assign rem_sh = (rem_i << 2) | (RW+2)'(bits_i);
  assign trial  = {root_i, 2'b01};
  assign fits   = (rem_sh >= trial);

  assign rem_o  = fits ? (rem_sh - trial) : rem_sh;
  assign root_o = {root_i[RW-2:0], fits};

endmodule

// File: rtl/sqrt_gen.sv
// Sequential integer square root: accepts a WIDTH-bit radicand, produces the
// floor root and remainder after RW enabled cycles, with valid/ready on both sides.
module sqrt_gen
  import sqrt_gen_pkg::*;
#(
  parameter int WIDTH = SQRT_DEFAULT_WIDTH
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               enb_i,
  input  logic [WIDTH-1:0]   dt_i,
  input  logic               valid_i,
  output logic               ready_o,
  output logic               busy_o,
  output logic [WIDTH/2-1:0] dt_o,
  output logic [WIDTH/2:0]   rem_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [1:0]         state_o
);

  localparam int RW = WIDTH / 2;
  localparam int CW = sqrt_cnt_width(RW);

  if (((WIDTH % 2) != 0) || (WIDTH < 4)) begin : g_bad_width
    $error("sqrt_gen: WIDTH must be even and at least 4");
  end

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high and enb_i is high; with enb_i low nothing moves and nothing is lost.
  sqrt_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [WIDTH-1:0] opnd_q;
  logic [RW-1:0] root_q, root_n;
  logic [RW+1:0] rem_q, rem_n;
  logic          accept, last_iter, release_out;

  assign accept      = valid_i && enb_i && (state_q == ST_IDLE);
  assign last_iter   = enb_i && (state_q == ST_CALC) && (cnt_q == '0);
  assign release_out = ready_i && enb_i && (state_q == ST_DONE);
  assign state_o     = state_q;

  sqrt_gen_step #(.RW(RW)) u_step (
    .root_i (root_q),
    .rem_i  (rem_q),
    .bits_i (opnd_q[WIDTH-1 -: 2]),
    .root_o (root_n),
    .rem_o  (rem_n)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)      state_d = ST_CALC;
      ST_CALC: if (last_iter)   state_d = ST_DONE;
      ST_DONE: if (release_out) state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ready_o = 1'b0;
    busy_o  = 1'b0;
    valid_o = 1'b0;
    case (state_q)
      ST_IDLE: ready_o = 1'b1;
      ST_CALC: busy_o  = 1'b1;
      ST_DONE: valid_o = 1'b1;
      default: ready_o = 1'b0;
    endcase
  end

  // Results are captured only on the last iteration and held through IDLE/CALC.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q  <= '0;
      opnd_q <= '0;
      root_q <= '0;
      rem_q  <= '0;
      dt_o   <= '0;
      rem_o  <= '0;
    end else if (accept) begin
      cnt_q  <= CW'(RW - 1);
      opnd_q <= dt_i;
      root_q <= '0;
      rem_q  <= '0;
    end else if (enb_i && (state_q == ST_CALC)) begin
      opnd_q <= opnd_q << 2;
      root_q <= root_n;
      rem_q  <= rem_n;
      if (cnt_q == '0) begin
        dt_o  <= root_n;
        rem_o <= rem_n[RW:0];
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sqrt_gen.sv
// Bench for sqrt_gen: directed corner tables at WIDTH 16 and 8, enable stalls,
// back-pressure, reset abort and randomized traffic against an arithmetic model.
module tb_sqrt_gen;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic enb = 1'b1;

  logic [15:0] dt16_i = '0;
  logic        valid16_i = 1'b0, rdy16_i = 1'b0;
  logic        ready16_o, busy16_o, valid16_o;
  logic [7:0]  dt16_o;
  logic [8:0]  rem16_o;
  logic [1:0]  state16_o;

  logic [7:0]  dt8_i = '0;
  logic        valid8_i = 1'b0, rdy8_i = 1'b0;
  logic        ready8_o, busy8_o, valid8_o;
  logic [3:0]  dt8_o;
  logic [4:0]  rem8_o;
  logic [1:0]  state8_o;

  int n_checks = 0;
  int n_fail = 0;
  logic [16:0] exp_q[$];

  typedef struct {
    logic [15:0] din;
    logic [7:0]  root;
    logic [8:0]  rem;
  } vec16_t;

  typedef struct {
    logic [7:0] din;
    logic [3:0] root;
    logic [4:0] rem;
  } vec8_t;

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  sqrt_gen #(.WIDTH(16)) u_dut16 (
    .clk_i(clk), .rstn_i(rstn), .enb_i(enb), .dt_i(dt16_i), .valid_i(valid16_i),
    .ready_o(ready16_o), .busy_o(busy16_o), .dt_o(dt16_o), .rem_o(rem16_o),
    .valid_o(valid16_o), .ready_i(rdy16_i), .state_o(state16_o)
  );

  sqrt_gen #(.WIDTH(8)) u_dut8 (
    .clk_i(clk), .rstn_i(rstn), .enb_i(enb), .dt_i(dt8_i), .valid_i(valid8_i),
    .ready_o(ready8_o), .busy_o(busy8_o), .dt_o(dt8_o), .rem_o(rem8_o),
    .valid_o(valid8_o), .ready_i(rdy8_i), .state_o(state8_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: floor square root by plain arithmetic, packed as {root, rem}.
  function automatic logic [16:0] model(input logic [15:0] x);
    int r;
    int rm;
    logic [7:0] rr;
    logic [8:0] rmm;
    r = $rtoi($sqrt(real'(x)));
    while (r * r > int'(x)) r--;
    while ((r + 1) * (r + 1) <= int'(x)) r++;
    rm = int'(x) - r * r;
    rr = r[7:0];
    rmm = rm[8:0];
    return {rr, rmm};
  endfunction

  // Called #1 after a rising edge with the 16-bit unit idle; leaves it in DONE.
  task automatic run_op16(input logic [15:0] din, input int stall_at, input int stall_len,
                          output logic [7:0] root, output logic [8:0] rem, output int lat);
    dt16_i = din;
    valid16_i = 1'b1;
    @(posedge clk); #1;
    valid16_i = 1'b0;
    dt16_i = 16'($urandom);
    lat = 0;
    while (!valid16_o && lat < 64) begin
      enb = (lat < stall_at || lat >= stall_at + stall_len);
      @(posedge clk); #1;
      lat++;
      if (lat == 1) check("calc_busy", {busy16_o, ready16_o, valid16_o}, 3'b100);
    end
    enb = 1'b1;
    root = dt16_o;
    rem = rem16_o;
  endtask

  task automatic release16();
    rdy16_i = 1'b1;
    @(posedge clk); #1;
    rdy16_i = 1'b0;
    check("back_to_idle", {ready16_o, busy16_o, valid16_o}, 3'b100);
  endtask

  task automatic run_op8(input logic [7:0] din, output logic [3:0] root,
                         output logic [4:0] rem, output int lat);
    dt8_i = din;
    valid8_i = 1'b1;
    @(posedge clk); #1;
    valid8_i = 1'b0;
    dt8_i = 8'($urandom);
    lat = 0;
    while (!valid8_o && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    root = dt8_o;
    rem = rem8_o;
    rdy8_i = 1'b1;
    @(posedge clk); #1;
    rdy8_i = 1'b0;
    check("w8_back_to_idle", {ready8_o, valid8_o}, 2'b10);
  endtask

  initial begin
    vec16_t vt16[6];
    vec8_t  vt8[3];
    logic [7:0] root;
    logic [8:0] rem;
    logic [3:0] root8;
    logic [4:0] rem8;
    logic [7:0] held_root;
    logic [16:0] expv;
    int lat;
    int cycles;
    int n_done;
    int sel;
    bit saw_valid;

    vt16[0] = '{16'd0,     8'd0,   9'd0};
    vt16[1] = '{16'd65535, 8'd255, 9'd510};
    vt16[2] = '{16'd144,   8'd12,  9'd0};
    vt16[3] = '{16'd145,   8'd12,  9'd1};
    vt16[4] = '{16'd1,     8'd1,   9'd0};
    vt16[5] = '{16'd65024, 8'd254, 9'd508};
    vt8[0]  = '{8'd255, 4'd15, 5'd30};
    vt8[1]  = '{8'd1,   4'd1,  5'd0};
    vt8[2]  = '{8'd99,  4'd9,  5'd18};

    // reset state
    #3;
    check("rst_w16", {ready16_o, busy16_o, valid16_o, dt16_o, rem16_o}, {3'b100, 17'd0});
    check("rst_w8", {ready8_o, busy8_o, valid8_o, dt8_o, rem8_o}, {3'b100, 9'd0});
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      run_op16(vt16[i].din, 100, 0, root, rem, lat);
      check($sformatf("w16_root_%0d", vt16[i].din), root, vt16[i].root);
      check($sformatf("w16_rem_%0d", vt16[i].din), rem, vt16[i].rem);
      check($sformatf("w16_lat_%0d", vt16[i].din), lat, 8);
      release16();
    end

    for (int i = 0; i < 3; i++) begin
      run_op8(vt8[i].din, root8, rem8, lat);
      check($sformatf("w8_root_%0d", vt8[i].din), root8, vt8[i].root);
      check($sformatf("w8_rem_%0d", vt8[i].din), rem8, vt8[i].rem);
      check($sformatf("w8_lat_%0d", vt8[i].din), lat, 4);
    end

    // enable stall in the middle of an operation
    run_op16(16'd1000, 2, 3, root, rem, lat);
    check("stall_root", root, 8'd31);
    check("stall_rem", rem, 9'd39);
    check("stall_lat", lat, 11);
    release16();

    // back-pressure, with an operand offered while the result is pending
    run_op16(16'd50000, 100, 0, root, rem, lat);
    held_root = root;
    check("bp_root", root, 8'd223);
    valid16_i = 1'b1;
    dt16_i = 16'd9;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_hold", {valid16_o, ready16_o, busy16_o, dt16_o, rem16_o}, {3'b100, held_root, 9'd271});
    end
    rdy16_i = 1'b1;
    @(posedge clk); #1;
    rdy16_i = 1'b0;
    check("bp_release_idle", {ready16_o, busy16_o, valid16_o}, 3'b100);
    valid16_i = 1'b0;

    // reset abort in the middle of CALC
    run_op16(16'd2000, 3, 100, root, rem, lat);
    enb = 1'b1;
    #2 rstn = 1'b0;
    #1;
    check("abort_outputs", {ready16_o, busy16_o, valid16_o, dt16_o, rem16_o}, {3'b100, 17'd0});
    @(negedge clk);
    rstn = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (valid16_o) saw_valid = 1'b1;
    end
    check("abort_no_valid", saw_valid, 1'b0);
    run_op16(16'd400, 100, 0, root, rem, lat);
    check("post_abort_root", root, 8'd20);
    check("post_abort_rem", rem, 9'd0);
    check("post_abort_lat", lat, 8);
    release16();

    // randomized back-to-back traffic
    n_done = 0;
    cycles = 0;
    while (n_done < 150 && cycles < 20000) begin
      valid16_i = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 9);
      dt16_i = (sel == 0) ? 16'd0 : (sel == 1) ? 16'hFFFF : 16'($urandom);
      rdy16_i = $urandom_range(0, 1);
      enb = ($urandom_range(0, 9) != 0);
      if (valid16_i && ready16_o && enb) exp_q.push_back(model(dt16_i));
      if (valid16_o && rdy16_i && enb) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rand_unexpected: got result %0d with nothing expected", dt16_o);
        end else begin
          expv = exp_q.pop_front();
          check("rand_result", {dt16_o, rem16_o}, expv);
        end
        n_done++;
      end
      @(posedge clk); #1;
      cycles++;
    end
    check("rand_progress", n_done, 150);

    valid16_i = 1'b0;
    rdy16_i = 1'b1;
    enb = 1'b1;
    cycles = 0;
    while (exp_q.size() > 0 && cycles < 50) begin
      if (valid16_o) begin
        expv = exp_q.pop_front();
        check("drain_result", {dt16_o, rem16_o}, expv);
      end
      @(posedge clk); #1;
      cycles++;
    end
    rdy16_i = 1'b0;
    check("drain_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
